// File: rtl/rob_occupancy_tracker.sv
// rob_occupancy_tracker: reorder-buffer head/tail/count tracking with per-entry valid bits and flush rollback.
module rob_occupancy_tracker #(
    parameter int ROB_SIZE    = 16,
    parameter int FULL_MARGIN = 0,
    parameter int PTR_W       = $clog2(ROB_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_req,
    output logic                alloc_ack,
    output logic [PTR_W-1:0]    alloc_tag,
    input  logic                retire_req,
    input  logic                retire_stall,
    output logic                retire_ack,
    input  logic                flush_valid,
    input  logic [PTR_W-1:0]    flush_tag,
    output logic                flush_err,
    output logic [31:0]         rob_head,
    output logic [PTR_W-1:0]    rob_tail,
    output logic [PTR_W:0]      rob_count,
    output logic                rob_full,
    output logic                rob_empty,
    output logic [ROB_SIZE-1:0] rob_valid
);
    typedef logic [PTR_W-1:0] ptr_t;
    ptr_t                head_q, head_d, tail_q, tail_d, surv_off;
    logic [PTR_W:0]      count_q, count_d;
    logic [ROB_SIZE-1:0] valid_q, valid_d;
    logic                err_q, err_d, flush_ok;
    assign alloc_ack  = reset & alloc_req & (count_q < (PTR_W+1)'(ROB_SIZE)) & ~flush_valid;
    assign retire_ack = reset & retire_req & ~retire_stall & (count_q != '0);
    assign alloc_tag  = tail_q;
    assign head_d     = head_q + ptr_t'(retire_ack);
    // A flush may not name the entry that retires in the same cycle
    assign flush_ok   = valid_q[flush_tag] & ~(retire_ack & (flush_tag == head_q));
    assign surv_off   = flush_tag - head_d;
    always_comb begin
        valid_d = valid_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = 1'b0;
        if (retire_ack) valid_d[head_q] = 1'b0;
        if (flush_valid && flush_ok) begin
            tail_d  = flush_tag + ptr_t'(1);
            count_d = {1'b0, surv_off} + (PTR_W+1)'(1);
            for (int i = 0; i < ROB_SIZE; i++)
                if (ptr_t'(i) - head_d > surv_off) valid_d[i] = 1'b0;
        end else if (flush_valid) begin
            err_d   = 1'b1;
            count_d = count_q - (PTR_W+1)'(retire_ack);
        end else begin
            if (alloc_ack) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + ptr_t'(1);
            end
            count_d = count_q + (PTR_W+1)'(alloc_ack) - (PTR_W+1)'(retire_ack);
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    assign flush_err = err_q;
    assign rob_head  = 32'(head_q);
    assign rob_tail  = tail_q;
    assign rob_count = count_q;
    assign rob_full  = int'(count_q) + FULL_MARGIN >= ROB_SIZE;
    assign rob_empty = count_q == '0;
    assign rob_valid = valid_q;
    a_popcount: assert property (@(posedge clk) disable iff (!reset) $countones(valid_q) == int'(count_q));
endmodule

// File: tb/tb_rob_occupancy_tracker.sv
// tb_rob_occupancy_tracker: directed + random checks of rob_occupancy_tracker against a head/count model.
module tb_rob_occupancy_tracker;
    localparam int N = 16;
    logic        clk = 1'b0, reset = 1'b0;
    logic        alloc_req = 1'b0, retire_req = 1'b0, retire_stall = 1'b0, flush_valid = 1'b0;
    logic [3:0]  flush_tag = '0;
    logic        alloc_ack, retire_ack, flush_err, rob_full, rob_empty;
    logic [3:0]  alloc_tag, rob_tail;
    logic [31:0] rob_head;
    logic [4:0]  rob_count;
    logic [15:0] rob_valid;
    int          n_chk = 0, n_fail = 0;
    int          m_head = 0, m_count = 0;
    bit          m_err = 0;
    logic        l_aack, l_rack;
    logic [3:0]  l_tag;

    rob_occupancy_tracker #(.ROB_SIZE(N), .FULL_MARGIN(0)) dut (
        .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_tag(alloc_tag),
        .retire_req(retire_req), .retire_stall(retire_stall), .retire_ack(retire_ack),
        .flush_valid(flush_valid), .flush_tag(flush_tag), .flush_err(flush_err),
        .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count), .rob_full(rob_full),
        .rob_empty(rob_empty), .rob_valid(rob_valid));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Live entries are the count slots starting at head, wrapping
    task automatic check_regs();
        logic [15:0] ev = '0;
        for (int i = 0; i < N; i++) ev[i] = ((i - m_head + N) % N) < m_count;
        chk("head", rob_head, 32'(m_head));
        chk("tail", 32'(rob_tail), 32'((m_head + m_count) % N));
        chk("count", 32'(rob_count), 32'(m_count));
        chk("full", 32'(rob_full), 32'(m_count >= N));
        chk("empty", 32'(rob_empty), 32'(m_count == 0));
        chk("valid", 32'(rob_valid), 32'(ev));
        chk("flush_err", 32'(flush_err), 32'(m_err));
        chk("popcount", 32'($countones(rob_valid)), 32'(rob_count));
    endtask

    task automatic step(input bit ar, input bit rr, input bit st, input bit fv, input int ft);
        bit eaa, era, ok;
        int nh;
        alloc_req = ar; retire_req = rr; retire_stall = st; flush_valid = fv; flush_tag = 4'(ft);
        #1;
        eaa = ar && m_count < N && !fv;
        era = rr && !st && m_count != 0;
        ok  = ((ft - m_head + N) % N) < m_count && !(era && ft == m_head);
        chk("alloc_ack", 32'(alloc_ack), 32'(eaa));
        chk("retire_ack", 32'(retire_ack), 32'(era));
        if (eaa) chk("alloc_tag", 32'(alloc_tag), 32'((m_head + m_count) % N));
        l_aack = alloc_ack; l_rack = retire_ack; l_tag = alloc_tag;
        @(posedge clk);
        nh = (m_head + int'(era)) % N;
        if (fv && ok) m_count = ((ft - nh + N) % N) + 1;
        else if (fv) m_count -= int'(era);
        else m_count += int'(eaa) - int'(era);
        m_err  = fv && !ok;
        m_head = nh;
        @(negedge clk);
        check_regs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        m_head = 0; m_count = 0; m_err = 0;
        @(negedge clk);
        reset = 1'b1;
        check_regs();
    endtask

    initial begin
        #12;
        chk("rst_count", 32'(rob_count), 0);
        chk("rst_empty", 32'(rob_empty), 1);
        chk("rst_full", 32'(rob_full), 0);
        chk("rst_aack", 32'(alloc_ack), 0);
        @(negedge clk);
        reset = 1'b1;
        check_regs();
        // Reset mid-run clears state asynchronously
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        chk("t1_count5", 32'(rob_count), 5);
        #2 reset = 1'b0;
        #1;
        chk("t1_count", 32'(rob_count), 0);
        chk("t1_head", rob_head, 0);
        chk("t1_tail", 32'(rob_tail), 0);
        chk("t1_valid", 32'(rob_valid), 0);
        chk("t1_empty", 32'(rob_empty), 1);
        do_reset();
        // Fill to full, then refused alloc, then alloc+retire while full
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 0);
            chk("t2_tag", 32'(l_tag), 32'(i));
        end
        chk("t2_full", 32'(rob_full), 1);
        step(1, 0, 0, 0, 0);
        chk("t2_17th", 32'(l_aack), 0);
        step(1, 1, 0, 0, 0);
        chk("t3_aack", 32'(l_aack), 0);
        chk("t3_rack", 32'(l_rack), 1);
        chk("t3_count", 32'(rob_count), 15);
        step(1, 0, 0, 0, 0);
        chk("t3_next_aack", 32'(l_aack), 1);
        // Wrap around from head=tail=14
        do_reset();
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            chk("t4_tag", 32'(l_tag), 32'((14 + i) % 16));
        end
        chk("t4_tail", 32'(rob_tail), 2);
        chk("t4_count", 32'(rob_count), 4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        chk("t4_empty", 32'(rob_empty), 1);
        // Valid flush rollback with concurrent alloc
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 5);
        chk("t5_aack", 32'(l_aack), 0);
        chk("t5_tail", 32'(rob_tail), 6);
        chk("t5_count", 32'(rob_count), 4);
        chk("t5_valid", 32'(rob_valid), 32'h003C);
        chk("t5_err", 32'(flush_err), 0);
        // Stalled retire, then invalid flush
        step(0, 1, 1, 0, 0);
        chk("t6_rack", 32'(l_rack), 0);
        chk("t6_head", rob_head, 2);
        step(0, 0, 0, 1, 12);
        chk("t6_err", 32'(flush_err), 1);
        chk("t6_tail", 32'(rob_tail), 6);
        chk("t6_count", 32'(rob_count), 4);
        step(0, 0, 0, 0, 0);
        chk("t6_err_clr", 32'(flush_err), 0);
        // Random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 8, int'($urandom_range(0, 15)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
